// File: rtl/cla_adder_pipe_if.sv
// Operand/result bundle for cla_adder_pipe.
//   slave  : the adder side (consumes in_valid/a/b/cin/sub/out_ready,
//            drives in_ready/out_valid/sum/cout/ovf)
//   master : the producer/consumer side, the mirror image of slave
interface cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// Operands are split into 4-bit CLA groups; a second lookahead level combines the
// group propagate/generate terms. The groups are spread evenly over STAGES register
// stages, each stage resolving its groups from the carry registered by the stage
// before it. Latency is STAGES cycles, throughput one beat per cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, drops every beat in flight
//   bus  - cla_adder_pipe_if.slave: in_valid/in_ready/a/b/cin/sub on the input side,
//          out_valid/out_ready/sum/cout/ovf on the output side
module cla_adder_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  cla_adder_pipe_if.slave bus
);

  localparam int unsigned NumGroups   = WIDTH / 4;
  localparam int unsigned GrpPerStage = NumGroups / STAGES;

  // Per-stage pipeline registers. b_q holds the effective operand (already inverted
  // for subtraction) so later stages never need to know about sub.
  logic [STAGES-1:0]            v_d, v_q;
  logic [STAGES-1:0]            c_d, c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_d, a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_d, b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_d, s_q;
  logic [STAGES-1:0]            ovf_s;
  logic                         ovf_d, ovf_q;
  logic                         en;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign en           = bus.out_ready | ~v_q[STAGES-1];
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned BaseGrp = k * GrpPerStage;

    logic             vi;
    logic             ci;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;

    if (k == 0) begin : g_first
      assign vi = bus.in_valid;
      assign ai = bus.a;
      assign bi = bus.sub ? ~bus.b : bus.b;
      assign ci = bus.sub | bus.cin;
      assign si = '0;
    end else begin : g_next
      assign vi = v_q[k-1];
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign ci = c_q[k-1];
      assign si = s_q[k-1];
    end

    logic [GrpPerStage-1:0] pg;
    logic [GrpPerStage-1:0] gg;
    logic [GrpPerStage:0]   gc;
    logic [WIDTH-1:0]       so;
    logic [3:0]             p;
    logic [3:0]             g;
    logic [3:0]             c;
    logic                   t;
    logic                   acc;
    logic                   c_msb;

    always_comb begin
      pg    = '0;
      gg    = '0;
      gc    = '0;
      so    = si;
      p     = '0;
      g     = '0;
      c     = '0;
      t     = 1'b0;
      acc   = 1'b0;
      c_msb = 1'b0;

      // Group propagate/generate.
      for (int j = 0; j < int'(GrpPerStage); j++) begin
        p     = ai[4*(int'(BaseGrp)+j) +: 4] ^ bi[4*(int'(BaseGrp)+j) +: 4];
        g     = ai[4*(int'(BaseGrp)+j) +: 4] & bi[4*(int'(BaseGrp)+j) +: 4];
        pg[j] = &p;
        gg[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      end

      // Second lookahead level: each group carry is a flat sum of products over the
      // stage's pg/gg terms and the incoming stage carry.
      gc[0] = ci;
      for (int j = 0; j < int'(GrpPerStage); j++) begin
        acc = ci;
        for (int m = 0; m <= j; m++) acc = acc & pg[m];
        for (int m = 0; m <= j; m++) begin
          t = gg[m];
          for (int n = m + 1; n <= j; n++) t = t & pg[n];
          acc = acc | t;
        end
        gc[j+1] = acc;
      end

      // In-group 4-bit lookahead and sum bits.
      for (int j = 0; j < int'(GrpPerStage); j++) begin
        p    = ai[4*(int'(BaseGrp)+j) +: 4] ^ bi[4*(int'(BaseGrp)+j) +: 4];
        g    = ai[4*(int'(BaseGrp)+j) +: 4] & bi[4*(int'(BaseGrp)+j) +: 4];
        c[0] = gc[j];
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        so[4*(int'(BaseGrp)+j) +: 4] = p ^ c;
        c_msb = c[3];
      end
    end

    assign v_d[k]   = vi;
    assign a_d[k]   = ai;
    assign b_d[k]   = bi;
    assign s_d[k]   = so;
    assign c_d[k]   = gc[GrpPerStage];
    // Only meaningful in the last stage, where c_msb is the carry into bit WIDTH-1.
    assign ovf_s[k] = c_msb ^ gc[GrpPerStage];
  end

  assign ovf_d = ovf_s[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Operand bits already resolved (and the whole last-stage operand copy) are dead.
  logic unused_ops;
  assign unused_ops = ^{a_q, b_q, ovf_s};

endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               cyc;
    int               stalls;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stalls   = 0;
  int   n_accept = 0;
  bit   head_seen = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint mod = longint'(1) << WIDTH;
    longint ua  = longint'(a);
    longint ub  = longint'(b);
    longint sa  = a[WIDTH-1] ? ua - mod : ua;
    longint sb_ = b[WIDTH-1] ? ub - mod : ub;
    longint r, rs;
    if (sub) begin
      r      = ua - ub;
      rs     = sa - sb_;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + longint'(cin);
      rs     = sa + sb_ + longint'(cin);
      e.cout = (r >= mod);
    end
    if (r < 0) r = r + mod;
    e.sum    = r[WIDTH-1:0];
    e.ovf    = (rs > (mod / 2) - 1) || (rs < -(mod / 2));
    e.cyc    = 0;
    e.stalls = 0;
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (sb.size() == 0) begin
        check("idle_out_valid", bus.out_valid, 1'b0);
      end else if (bus.out_valid) begin
        check("result", {bus.ovf, bus.cout, bus.sum}, {sb[0].ovf, sb[0].cout, sb[0].sum});
        if (!head_seen) begin
          head_seen = 1'b1;
          if (sb[0].stalls == stalls) check("latency", cyc - sb[0].cyc, STAGES);
        end
        check("in_ready", bus.in_ready, bus.out_ready);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e        = model(bus.a, bus.b, bus.cin, bus.sub);
        e.cyc    = cyc;
        e.stalls = stalls;
        sb.push_back(e);
        n_accept++;
      end
      if (bus.out_valid && !bus.out_ready) stalls++;
    end
    cyc++;
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    int n = 0;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, '0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed arithmetic corners.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle(4);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle(4);
    send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0); idle(4);
    send(16'h0005, 16'h0007, 1'b1, 1'b1); idle(4);
    send(16'h8000, 16'h0001, 1'b0, 1'b1); idle(4);
    drain();

    // Back-to-back stream with a 3-cycle output stall after the first result.
    fork
      begin
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (n >= 20) check("stream_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while two beats are in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    send(16'hABCD, 16'h1234, 1'b1, 1'b0); idle(4);
    drain();

    // Random traffic with random bubbles and backpressure.
    begin
      int target = n_accept + 3000;
      int guard  = 0;
      while (n_accept < target && guard < 40000) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 9) < 7);
        bus.a         = WIDTH'($urandom);
        bus.b         = WIDTH'($urandom);
        bus.cin       = 1'($urandom);
        bus.sub       = 1'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 40000) check("random_timeout", 1'b0, 1'b1);
    end
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
